edsac_tank_bank: RTL and testbench

//  Parametrised bank of NUM_TANKS recirculating serial delay-line tanks, each WORDS x WORD_BITS bits,

---
 rtl/edsac_mem_pkg.sv | 22 ++
 rtl/edsac_tank.sv | 47 ++++
 rtl/edsac_tank_bank.sv | 153 +++++++++++++++
 tb/tb_edsac_tank_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edsac_mem_pkg.sv
// Shared definitions for the EDSAC delay-line tank bank: default geometry,
// access FSM state encoding and the tank length helper.
package edsac_mem_pkg;

  localparam int unsigned DefNumTanks = 4;
  localparam int unsigned DefWords    = 32;
  localparam int unsigned DefWordBits = 18;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StXfer,
    StDone
  } tank_state_e;

  // Total digit positions circulating in one tank.
  function automatic int unsigned tank_bits(input int unsigned words,
                                            input int unsigned word_bits);
    return words * word_bits;
  endfunction

endpackage

// File: rtl/edsac_tank.sv
// One recirculating serial delay line. The head bit leaves every cycle and a
// new tail bit enters: zero while clearing, write data while writing, else the
// head recirculates. Optional raw contents port when EDSAC_MONITOR_EN is defined.
module edsac_tank #(
  parameter int unsigned TANK_BITS = 576
) (
  input  logic                 clk,
  input  logic                 tn_rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic                 din,
  output logic                 head
`ifdef EDSAC_MONITOR_EN
  ,
  output logic [TANK_BITS-1:0] contents
`endif
);

  logic [TANK_BITS-1:0] bits_q, bits_d;
  logic                 tail;

  // Tail selection: clear beats write beats recirculation.
  always_comb begin
    tail = bits_q[0];
    if (clr) begin
      tail = 1'b0;
    end else if (wr_en) begin
      tail = din;
    end
    bits_d = {tail, bits_q[TANK_BITS-1:1]};
  end

  // Shift the whole line one position every cycle.
  always_ff @(posedge clk or negedge tn_rst) begin
    if (!tn_rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign head = bits_q[0];
`ifdef EDSAC_MONITOR_EN
  assign contents = bits_q;
`endif

endmodule

// File: rtl/edsac_tank_bank.sv
// Bank of NUM_TANKS recirculating tanks sharing one digit/minor-cycle counter.
// A req/ack FSM waits for the addressed word to reach the heads, then moves it
// serially (LSB first) on mib/mob for WORD_BITS cycles.
// Build option EDSAC_MONITOR_EN exposes the raw tank contents on 'monitor'.
module edsac_tank_bank
  import edsac_mem_pkg::*;
#(
  parameter int unsigned NUM_TANKS = DefNumTanks,
  parameter int unsigned WORDS     = DefWords,
  parameter int unsigned WORD_BITS = DefWordBits,
  parameter int unsigned TANK_W    = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1,
  parameter int unsigned WORD_W    = $clog2(WORDS),
  parameter int unsigned DIG_W     = $clog2(WORD_BITS)
) (
  input  logic                     clk,
  input  logic                     tn_rst,
  input  logic                     tn_clr,
  input  logic                     acc_req,
  input  logic                     acc_wr,
  input  logic [TANK_W+WORD_W-1:0] acc_addr,
  input  logic                     mib,
  output logic                     mob,
  output logic                     xfer,
  output logic [DIG_W-1:0]         dig,
  output logic                     acc_ack
`ifdef EDSAC_MONITOR_EN
  ,
  output logic [NUM_TANKS*WORDS*WORD_BITS-1:0] monitor
`endif
);

  localparam int unsigned TANK_BITS = tank_bits(WORDS, WORD_BITS);
  localparam int unsigned ADDR_W    = TANK_W + WORD_W;

  logic [DIG_W-1:0]     dig_q, dig_d;
  logic [WORD_W-1:0]    minor_q, minor_d;
  tank_state_e          state_q, state_d;
  logic                 wr_q, wr_d;
  logic [TANK_W-1:0]    tank_q, tank_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 dig_last;
  logic                 clr_en;
  logic                 head_sel;
  logic [NUM_TANKS-1:0] head;
  logic [NUM_TANKS-1:0] wr_en;

  // Free-running digit / minor-cycle counter, next value.
  always_comb begin
    dig_last = (dig_q == DIG_W'(WORD_BITS - 1));
    dig_d    = dig_last ? '0 : dig_q + 1'b1;
    minor_d  = minor_q;
    if (dig_last) begin
      minor_d = (minor_q == WORD_W'(WORDS - 1)) ? '0 : minor_q + 1'b1;
    end
  end

  // Access FSM next state. Entry to XFER is decided from the next counter value
  // so that the first XFER cycle coincides with digit 0 of the addressed word.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    tank_d  = tank_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (acc_req) begin
          wr_d    = acc_wr;
          tank_d  = acc_addr[ADDR_W-1:WORD_W];
          word_d  = acc_addr[WORD_W-1:0];
          state_d = (minor_d == acc_addr[WORD_W-1:0] && dig_d == '0) ? StXfer : StWait;
        end
      end
      StWait: begin
        if (minor_d == word_q && dig_d == '0) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (dig_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Timing counter registers.
  always_ff @(posedge clk or negedge tn_rst) begin
    if (!tn_rst) begin
      dig_q   <= '0;
      minor_q <= '0;
    end else begin
      dig_q   <= dig_d;
      minor_q <= minor_d;
    end
  end

  // FSM state and latched request.
  always_ff @(posedge clk or negedge tn_rst) begin
    if (!tn_rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      tank_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      tank_q  <= tank_d;
      word_q  <= word_d;
    end
  end

  // Per-tank write gating and head select; an out-of-range tank matches none.
  always_comb begin
    head_sel = 1'b0;
    wr_en    = '0;
    for (int t = 0; t < NUM_TANKS; t++) begin
      if (tank_q == TANK_W'(t)) begin
        head_sel = head[t];
        wr_en[t] = (state_q == StXfer) && wr_q;
      end
    end
  end

  assign clr_en  = ~tn_clr;
  assign xfer    = (state_q == StXfer);
  assign acc_ack = (state_q == StDone);
  assign mob     = head_sel & xfer & ~wr_q;
  assign dig     = dig_q;

  for (genvar g = 0; g < NUM_TANKS; g++) begin : g_tank
    edsac_tank #(
      .TANK_BITS(TANK_BITS)
    ) u_tank (
      .clk     (clk),
      .tn_rst  (tn_rst),
      .clr     (clr_en),
      .wr_en   (wr_en[g]),
      .din     (mib),
      .head    (head[g])
`ifdef EDSAC_MONITOR_EN
      ,
      .contents(monitor[g*TANK_BITS +: TANK_BITS])
`endif
    );
  end

endmodule

// File: tb/tb_edsac_tank_bank.sv
// Directed bench for edsac_tank_bank (default geometry, 4 x 32 x 18).
// A small memory model feeds a queue of expected read words; each read pops
// and compares when the DUT finishes serialising the word.
module tb_edsac_tank_bank;

  logic       clk;
  logic       tn_rst;
  logic       tn_clr;
  logic       acc_req;
  logic       acc_wr;
  logic [6:0] acc_addr;
  logic       mib;
  logic       mob;
  logic       xfer;
  logic [4:0] dig;
  logic       acc_ack;
`ifdef EDSAC_MONITOR_EN
  logic [4*576-1:0] monitor;
`endif

  edsac_tank_bank u_dut (
    .clk     (clk),
    .tn_rst  (tn_rst),
    .tn_clr  (tn_clr),
    .acc_req (acc_req),
    .acc_wr  (acc_wr),
    .acc_addr(acc_addr),
    .mib     (mib),
    .mob     (mob),
    .xfer    (xfer),
    .dig     (dig),
    .acc_ack (acc_ack)
`ifdef EDSAC_MONITOR_EN
    ,
    .monitor (monitor)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          mdig = 0;
  int          mminor = 0;
  logic [17:0] mem [4][32];
  logic [17:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and the reference counter; outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!tn_rst) begin
      mdig   = 0;
      mminor = 0;
    end else if (mdig == 17) begin
      mdig   = 0;
      mminor = (mminor + 1) % 32;
    end else begin
      mdig = mdig + 1;
    end
  endtask

  task automatic goto(input int m, input int d);
    while (!(mminor == m && mdig == d)) tick();
  endtask

  task automatic clear_model();
    for (int t = 0; t < 4; t++)
      for (int w = 0; w < 32; w++)
        mem[t][w] = '0;
  endtask

  // Wait (bounded) for xfer; lat counts cycles from the request cycle.
  task automatic wait_xfer(output int lat);
    lat = 1;
    while (!xfer && lat < 700) begin
      tick();
      lat++;
    end
  endtask

  // Full access: request in the current cycle, serialise, check handshake.
  task automatic access(input logic wr, input int t, input int w, input logic [17:0] data,
                        input logic poke, input logic clr_x, output int lat);
    logic [17:0] got;
    logic [17:0] expw;
    int          nx;
    if (!wr) exp_q.push_back(mem[t][w]);
    acc_req  = 1'b1;
    acc_wr   = wr;
    acc_addr = {t[1:0], w[4:0]};
    tick();
    acc_req = poke;
    wait_xfer(lat);
    if (!xfer) begin
      check($sformatf("xfer_timeout t%0d w%0d", t, w), {31'b0, xfer}, 32'd1);
      acc_req = 1'b0;
      if (!wr) void'(exp_q.pop_front());
      return;
    end
    nx  = 0;
    got = '0;
    for (int k = 0; k < 18; k++) begin
      mib = wr ? data[k] : 1'b0;
      if (clr_x) tn_clr = 1'b0;
      got[k] = mob;
      if (xfer) nx++;
      tick();
    end
    tn_clr  = 1'b1;
    mib     = 1'b0;
    acc_req = 1'b0;
    check("xfer_width", nx, 32'd18);
    check("ack_rise", {31'b0, acc_ack}, 32'd1);
    check("xfer_fall", {31'b0, xfer}, 32'd0);
    tick();
    check("ack_fall", {31'b0, acc_ack}, 32'd0);
    if (wr) begin
      if (clr_x) begin
        for (int tt = 0; tt < 4; tt++) mem[tt][w] = '0;
      end else begin
        mem[t][w] = data;
      end
    end else begin
      expw = exp_q.pop_front();
      check($sformatf("read t%0d w%0d", t, w), {14'b0, got}, {14'b0, expw});
    end
  endtask

  initial begin
    int lat;
    int flag;
    tn_rst   = 1'b0;
    tn_clr   = 1'b1;
    acc_req  = 1'b0;
    acc_wr   = 1'b0;
    acc_addr = '0;
    mib      = 1'b0;
    clear_model();

    // Reset state.
    tick();
    tick();
    check("rst_mob", {31'b0, mob}, 32'd0);
    check("rst_xfer", {31'b0, xfer}, 32'd0);
    check("rst_ack", {31'b0, acc_ack}, 32'd0);
    check("rst_dig", {27'b0, dig}, 32'd0);
    tn_rst = 1'b1;
    mdig   = 0;
    mminor = 0;

    // One idle revolution: nothing moves on the handshake, counter tracks.
    flag = 0;
    repeat (576) begin
      tick();
      if (xfer || acc_ack || mob) flag++;
    end
    check("idle_quiet", flag, 32'd0);
    check("idle_dig", {27'b0, dig}, mdig);

    // Write then read back, plus neighbouring words stay zero.
    access(1'b1, 1, 3, 18'h2A5A5, 1'b0, 1'b0, lat);
    access(1'b0, 1, 3, '0, 1'b0, 1'b0, lat);
    access(1'b0, 0, 3, '0, 1'b0, 1'b0, lat);
    access(1'b0, 1, 4, '0, 1'b0, 1'b0, lat);

`ifdef EDSAC_MONITOR_EN
    goto(0, 0);
    check("monitor_t1w3", {14'b0, monitor[576+54 +: 18]}, 32'h2A5A5);
`endif

    // Latency boundaries: addressed word just at the head vs next word.
    goto(3, 0);
    check("dig_align", {27'b0, dig}, 32'd0);
    access(1'b0, 1, 3, '0, 1'b0, 1'b0, lat);
    check("lat_full_rev", lat, 32'd576);
    goto(3, 0);
    access(1'b0, 1, 4, '0, 1'b0, 1'b0, lat);
    check("lat_next_word", lat, 32'd18);

    // Requests held during WAIT/XFER are ignored: one transfer, one ack.
    goto(20, 7);
    access(1'b1, 3, 10, 18'h1F0E1, 1'b1, 1'b0, lat);
    flag = 0;
    repeat (600) begin
      tick();
      if (xfer || acc_ack) flag++;
    end
    check("no_extra_xfer", flag, 32'd0);
    access(1'b0, 3, 10, '0, 1'b0, 1'b0, lat);

    // Fill word 31 in every tank, then a full-revolution clear.
    for (int t = 0; t < 4; t++) access(1'b1, t, 31, 18'h3FFFF, 1'b0, 1'b0, lat);
    access(1'b0, 2, 31, '0, 1'b0, 1'b0, lat);
    tn_clr = 1'b0;
    repeat (576) tick();
    tn_clr = 1'b1;
    clear_model();
    for (int t = 0; t < 4; t++) access(1'b0, t, 31, '0, 1'b0, 1'b0, lat);

    // Clear held only across a write transfer wins over the write data.
    access(1'b1, 2, 6, 18'h15555, 1'b0, 1'b0, lat);
    access(1'b1, 2, 5, 18'h15555, 1'b0, 1'b1, lat);
    access(1'b0, 2, 5, '0, 1'b0, 1'b0, lat);
    access(1'b0, 2, 6, '0, 1'b0, 1'b0, lat);

    // Reset in the middle of a write transfer.
    access(1'b1, 0, 2, 18'h0ABCD, 1'b0, 1'b0, lat);
    acc_req  = 1'b1;
    acc_wr   = 1'b1;
    acc_addr = {2'd0, 5'd2};
    tick();
    acc_req = 1'b0;
    wait_xfer(lat);
    check("pre_rst_xfer", {31'b0, xfer}, 32'd1);
    repeat (5) begin
      mib = 1'b1;
      tick();
    end
    mib    = 1'b0;
    tn_rst = 1'b0;
    #1;
    check("rst_mid_xfer", {31'b0, xfer}, 32'd0);
    check("rst_mid_ack", {31'b0, acc_ack}, 32'd0);
    flag = 0;
    repeat (3) begin
      tick();
      if (acc_ack || xfer) flag++;
    end
    check("rst_no_ack", flag, 32'd0);
    tn_rst = 1'b1;
    mdig   = 0;
    mminor = 0;
    clear_model();
    access(1'b0, 0, 2, '0, 1'b0, 1'b0, lat);
    check("post_rst_dig", {27'b0, dig}, mdig);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
